rx_command_controller: RTL and testbench
========================================

RX_COMMAND_CONTROLLER -- requirements
Module: rx_command_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the byte width of the receive data and of the operand/write-data outputs.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the register address width; the address is taken from byte bits [ADDR_WIDTH-1:0].
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the maximum number of idle clk cycles allowed between bytes of one command.
REQ-004 clk  in  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 rx_data  in  DATA_WIDTH  SHALL be the received byte from the UART receiver.
REQ-007 rx_data_valid  in  1  SHALL be a one-cycle strobe marking rx_data as a new byte.
REQ-008 rx_parity_error, rx_frame_error  in  1 each  SHALL flag a corrupted byte (sampled with rx_data_valid).
REQ-009 exec_busy  in  1  SHALL indicate the register file/ALU cannot accept a command this cycle.
REQ-010 reg_write_enable, reg_read_enable, alu_enable  out  1 each  SHALL be one-cycle issue strobes.
REQ-011 reg_address  out  ADDR_WIDTH; reg_write_data, operand_a, operand_b  out  DATA_WIDTH; alu_function  out  4  SHALL carry command fields, held stable from issue until the next command is issued.
REQ-012 command_error  out  1  SHALL be a one-cycle strobe on any aborted or rejected command.
REQ-013 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-014 Command bytes SHALL be: 0xAA write (addr, data), 0xBB read (addr), 0xCC ALU with operands (A, B, func), 0xDD ALU without operands (func).
REQ-015 States SHALL be IDLE, WAIT_ADDR, WAIT_WDATA, WAIT_OPA, WAIT_OPB, WAIT_FUNC, ISSUE.
REQ-016 IDLE: valid clean byte 0xAA/0xBB -> WAIT_ADDR; 0xCC -> WAIT_OPA; 0xDD -> WAIT_FUNC; any other byte -> stay IDLE, command_error strobe next cycle.
REQ-017 WAIT_ADDR: byte latched to reg_address; write -> WAIT_WDATA, read -> ISSUE.
REQ-018 WAIT_WDATA -> ISSUE latching reg_write_data; WAIT_OPA -> WAIT_OPB latching operand_a; WAIT_OPB -> WAIT_FUNC latching operand_b; WAIT_FUNC -> ISSUE latching alu_function = byte[3:0].
REQ-019 ISSUE: while exec_busy=1 stay in ISSUE, no strobe; first cycle with exec_busy=0 assert exactly one strobe (write/read/alu per command) for one cycle and return to IDLE.
REQ-020 0xDD SHALL issue alu_enable with operand_a/operand_b unchanged from their last loaded values (0 after reset).
REQ-021 A byte with rx_parity_error or rx_frame_error high SHALL be discarded; in IDLE it SHALL strobe command_error only; in any WAIT_* state it SHALL also abort to IDLE.
REQ-022 A byte arriving in ISSUE SHALL be discarded and strobe command_error; the pending command SHALL still issue.
REQ-023 Timeout counter SHALL clear on every accepted byte and count each cycle in WAIT_* states; on reaching TIMEOUT_CYCLES the FSM SHALL abort to IDLE with command_error; counter SHALL not run in IDLE or ISSUE.
REQ-024 Error, issue and timeout in the same cycle SHALL yield at most one command_error strobe per cycle; a strobe and an error SHALL never both abort a command already in ISSUE.
REQ-025 Latency: issue strobe SHALL assert 1 cycle after the last byte's rx_data_valid when exec_busy=0.

Reset
REQ-026 Reset SHALL force state IDLE, timeout counter 0, all strobes 0, all field outputs 0, busy 0, asynchronously and independent of clk.
REQ-027 Reset asserted mid-command SHALL discard the partial command with no strobe and no command_error.

Verification
REQ-028 Bytes 0xAA,0x05,0x3C, exec_busy=0 -> one reg_write_enable pulse with reg_address=5, reg_write_data=0x3C, 1 cycle after last strobe.
REQ-029 Bytes 0xCC,0x12,0x34,0x07 with exec_busy=1 for 10 cycles -> no strobe during busy, then alu_enable pulse, operand_a=0x12, operand_b=0x34, alu_function=7; then 0xDD,0x02 -> alu_enable with same operands, function 2.
REQ-030 Byte 0x55 in IDLE -> command_error pulse, state remains IDLE, no enables.
REQ-031 0xBB then byte with rx_parity_error=1 -> command_error pulse, IDLE, no reg_read_enable; next 0xBB,0x09 -> reg_read_enable, reg_address=9.
REQ-032 0xAA,0x03 then no byte for TIMEOUT_CYCLES cycles -> command_error pulse, busy falls, no reg_write_enable.
REQ-033 reset pulsed after 0xCC,0x11 -> all outputs 0, IDLE, no command_error; fresh 0xBB,0x01 completes normally.

Source files
------------

// File: rtl/rx_command_controller_if.sv
// Bundles the UART receive side, the execution-unit handshake and the
// decoded command fields of rx_command_controller.
interface rx_command_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_data_valid;
  logic                  rx_parity_error;
  logic                  rx_frame_error;
  logic                  exec_busy;
  logic                  reg_write_enable;
  logic                  reg_read_enable;
  logic                  alu_enable;
  logic [ADDR_WIDTH-1:0] reg_address;
  logic [DATA_WIDTH-1:0] reg_write_data;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [3:0]            alu_function;
  logic                  command_error;
  logic                  busy;

  modport slave (
    input  rx_data, rx_data_valid, rx_parity_error, rx_frame_error, exec_busy,
    output reg_write_enable, reg_read_enable, alu_enable, reg_address,
           reg_write_data, operand_a, operand_b, alu_function, command_error, busy
  );

  modport master (
    output rx_data, rx_data_valid, rx_parity_error, rx_frame_error, exec_busy,
    input  reg_write_enable, reg_read_enable, alu_enable, reg_address,
           reg_write_data, operand_a, operand_b, alu_function, command_error, busy
  );
endinterface

// File: rtl/rx_command_controller.sv
// Parses UART command bytes into register-file / ALU commands and issues
// one strobe per completed command, with corruption and inter-byte timeout aborts.
module rx_command_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  rx_command_controller_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU   = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU0  = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ADDR,
    S_WAIT_WDATA,
    S_WAIT_OPA,
    S_WAIT_OPB,
    S_WAIT_FUNC,
    S_ISSUE
  } state_t;

  typedef enum logic [1:0] {
    K_WRITE,
    K_READ,
    K_ALU
  } kind_t;

  state_t                state_q, state_n;
  kind_t                 kind_q, kind_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [DATA_WIDTH-1:0] opa_q, opa_n;
  logic [DATA_WIDTH-1:0] opb_q, opb_n;
  logic [3:0]            func_q, func_n;
  logic                  err_q, err_n;
  logic                  wr_stb, rd_stb, alu_stb;
  logic                  byte_ok, byte_bad, in_wait;

  assign byte_ok  = bus.rx_data_valid & ~bus.rx_parity_error & ~bus.rx_frame_error;
  assign byte_bad = bus.rx_data_valid & (bus.rx_parity_error | bus.rx_frame_error);
  assign in_wait  = (state_q != S_IDLE) && (state_q != S_ISSUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_WRITE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      func_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      kind_q  <= kind_n;
      cnt_q   <= cnt_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      opa_q   <= opa_n;
      opb_q   <= opb_n;
      func_q  <= func_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    kind_n  = kind_q;
    cnt_n   = '0;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    opa_n   = opa_q;
    opb_n   = opb_q;
    func_n  = func_q;
    err_n   = 1'b0;
    wr_stb  = 1'b0;
    rd_stb  = 1'b0;
    alu_stb = 1'b0;

    if (state_q == S_IDLE) begin
      if (byte_bad) begin
        err_n = 1'b1;
      end else if (byte_ok) begin
        case (bus.rx_data)
          CMD_WRITE: begin kind_n = K_WRITE; state_n = S_WAIT_ADDR; end
          CMD_READ:  begin kind_n = K_READ;  state_n = S_WAIT_ADDR; end
          CMD_ALU:   begin kind_n = K_ALU;   state_n = S_WAIT_OPA;  end
          CMD_ALU0:  begin kind_n = K_ALU;   state_n = S_WAIT_FUNC; end
          default:   err_n = 1'b1;
        endcase
      end
    end else if (state_q == S_ISSUE) begin
      // A stray byte only raises the error; the pending command still issues.
      err_n = bus.rx_data_valid;
      if (!bus.exec_busy) begin
        wr_stb  = (kind_q == K_WRITE);
        rd_stb  = (kind_q == K_READ);
        alu_stb = (kind_q == K_ALU);
        state_n = S_IDLE;
      end
    end else if (in_wait) begin
      if (byte_bad) begin
        err_n   = 1'b1;
        state_n = S_IDLE;
      end else if (byte_ok) begin
        case (state_q)
          S_WAIT_ADDR: begin
            addr_n  = bus.rx_data[ADDR_WIDTH-1:0];
            state_n = (kind_q == K_WRITE) ? S_WAIT_WDATA : S_ISSUE;
          end
          S_WAIT_WDATA: begin wdata_n = bus.rx_data; state_n = S_ISSUE;     end
          S_WAIT_OPA:   begin opa_n   = bus.rx_data; state_n = S_WAIT_OPB;  end
          S_WAIT_OPB:   begin opb_n   = bus.rx_data; state_n = S_WAIT_FUNC; end
          S_WAIT_FUNC:  begin func_n  = bus.rx_data[3:0]; state_n = S_ISSUE; end
          default:      state_n = S_IDLE;
        endcase
      end else if (cnt_q == CNT_LAST) begin
        err_n   = 1'b1;
        state_n = S_IDLE;
      end else begin
        cnt_n = cnt_q + CW'(1);
      end
    end
  end

  assign bus.reg_write_enable = wr_stb;
  assign bus.reg_read_enable  = rd_stb;
  assign bus.alu_enable       = alu_stb;
  assign bus.reg_address      = addr_q;
  assign bus.reg_write_data   = wdata_q;
  assign bus.operand_a        = opa_q;
  assign bus.operand_b        = opb_q;
  assign bus.alu_function     = func_q;
  assign bus.command_error    = err_q;
  assign bus.busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_command_controller.sv
// Directed and randomized command streams checked against a command-level
// model of the expected strobes and held field values.
module tb_rx_command_controller;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n_wr = 0, n_rd = 0, n_alu = 0, n_err = 0, n_multi = 0;

  logic [3:0] m_addr, m_func;
  logic [7:0] m_wdata, m_a, m_b;

  rx_command_controller_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  rx_command_controller #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.reg_write_enable) n_wr <= n_wr + 1;
    if (bus.reg_read_enable)  n_rd <= n_rd + 1;
    if (bus.alu_enable)       n_alu <= n_alu + 1;
    if (bus.command_error)    n_err <= n_err + 1;
    if (32'(bus.reg_write_enable) + 32'(bus.reg_read_enable) + 32'(bus.alu_enable) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pe, input logic fe);
    bus.rx_data = b;
    bus.rx_data_valid = 1'b1;
    bus.rx_parity_error = pe;
    bus.rx_frame_error = fe;
    tick();
    bus.rx_data_valid = 1'b0;
    bus.rx_parity_error = 1'b0;
    bus.rx_frame_error = 1'b0;
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_addr"},  32'(bus.reg_address),    32'(m_addr));
    check({tag, "_wdata"}, 32'(bus.reg_write_data), 32'(m_wdata));
    check({tag, "_opa"},   32'(bus.operand_a),      32'(m_a));
    check({tag, "_opb"},   32'(bus.operand_b),      32'(m_b));
    check({tag, "_func"},  32'(bus.alu_function),   32'(m_func));
  endtask

  // kind: 0 write, 1 read, 2 alu with operands, 3 alu without operands, 4 unknown byte
  task automatic run_cmd(input string tag, input int kind, input logic [7:0] f1,
                         input logic [7:0] f2, input logic [7:0] f3,
                         input int corrupt_at, input int nbusy, input bit stray);
    logic [7:0] b [4];
    int role [4];
    int n;
    int s_wr, s_rd, s_alu, s_err;
    int exp_err;
    bit aborted;
    logic en_obs;
    logic pe;
    s_wr = n_wr; s_rd = n_rd; s_alu = n_alu; s_err = n_err;
    exp_err = 0;
    aborted = 1'b0;
    for (int i = 0; i < 4; i++) begin b[i] = 8'h00; role[i] = 0; end
    case (kind)
      0: begin b[0] = 8'hAA; b[1] = f1; b[2] = f2; role[1] = 1; role[2] = 2; n = 3; end
      1: begin b[0] = 8'hBB; b[1] = f1; role[1] = 1; n = 2; end
      2: begin b[0] = 8'hCC; b[1] = f1; b[2] = f2; b[3] = f3;
               role[1] = 3; role[2] = 4; role[3] = 5; n = 4; end
      3: begin b[0] = 8'hDD; b[1] = f1; role[1] = 5; n = 2; end
      default: begin b[0] = f1; n = 1; end
    endcase
    for (int i = 0; i < n; i++) begin
      if (i == corrupt_at) begin
        pe = 1'($urandom_range(0, 1));
        send_byte(b[i], pe, ~pe);
        check({tag, "_cerr"}, 32'(bus.command_error), 1);
        exp_err = 1;
        aborted = 1'b1;
        break;
      end
      if (i == n - 1) bus.exec_busy = (nbusy > 0);
      send_byte(b[i], 1'b0, 1'b0);
      case (role[i])
        1: m_addr = b[i][3:0];
        2: m_wdata = b[i];
        3: m_a = b[i];
        4: m_b = b[i];
        5: m_func = b[i][3:0];
        default: ;
      endcase
    end
    if (!aborted && kind == 4) begin
      check({tag, "_uerr"}, 32'(bus.command_error), 1);
      exp_err = 1;
    end
    if (!aborted && kind != 4) begin
      if (nbusy > 0) begin
        for (int i = 0; i < nbusy; i++) begin
          if (i == 0 && stray) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
          else tick();
        end
        if (stray) exp_err = 1;
        check({tag, "_hold"}, 32'(n_wr + n_rd + n_alu - s_wr - s_rd - s_alu), 0);
        check({tag, "_holdbusy"}, 32'(bus.busy), 1);
        bus.exec_busy = 1'b0;
        #1;
      end
      en_obs = (kind == 0) ? bus.reg_write_enable :
               (kind == 1) ? bus.reg_read_enable : bus.alu_enable;
      check({tag, "_lat"}, 32'(en_obs), 1);
      tick();
    end
    bus.exec_busy = 1'b0;
    tick();
    check({tag, "_nwr"},  32'(n_wr - s_wr),   32'((!aborted && kind == 0) ? 1 : 0));
    check({tag, "_nrd"},  32'(n_rd - s_rd),   32'((!aborted && kind == 1) ? 1 : 0));
    check({tag, "_nalu"}, 32'(n_alu - s_alu), 32'((!aborted && (kind == 2 || kind == 3)) ? 1 : 0));
    check({tag, "_nerr"}, 32'(n_err - s_err), 32'(exp_err));
    check({tag, "_idle"}, 32'(bus.busy), 0);
    check_fields(tag);
  endtask

  initial begin
    int s_err, s_wr, kind, n, ca, v;
    bus.rx_data = 8'h00;
    bus.rx_data_valid = 1'b0;
    bus.rx_parity_error = 1'b0;
    bus.rx_frame_error = 1'b0;
    bus.exec_busy = 1'b0;
    m_addr = '0; m_wdata = '0; m_a = '0; m_b = '0; m_func = '0;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_strobes", 32'({bus.reg_write_enable, bus.reg_read_enable, bus.alu_enable,
                              bus.command_error}), 0);
    check_fields("rst");
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_cmd("wr_basic", 0, 8'h05, 8'h3C, 8'h00, 99, 0, 1'b0);
    check("wr_basic_addr5", 32'(bus.reg_address), 5);
    check("wr_basic_data3c", 32'(bus.reg_write_data), 32'h3C);
    run_cmd("alu_busy", 2, 8'h12, 8'h34, 8'h07, 99, 10, 1'b0);
    run_cmd("alu0", 3, 8'h02, 8'h00, 8'h00, 99, 0, 1'b0);
    check("alu0_opa_kept", 32'(bus.operand_a), 32'h12);
    check("alu0_opb_kept", 32'(bus.operand_b), 32'h34);
    run_cmd("bad_cmd", 4, 8'h55, 8'h00, 8'h00, 99, 0, 1'b0);
    run_cmd("rd_parity", 1, 8'h09, 8'h00, 8'h00, 1, 0, 1'b0);
    run_cmd("rd_ok", 1, 8'h09, 8'h00, 8'h00, 99, 0, 1'b0);
    run_cmd("rd_stray", 1, 8'h0E, 8'h00, 8'h00, 99, 3, 1'b1);

    // inter-byte timeout after the address byte
    s_err = n_err; s_wr = n_wr;
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    m_addr = 4'h3;
    for (int i = 0; i < TMO - 1; i++) tick();
    check("tmo_busy_before", 32'(bus.busy), 1);
    check("tmo_noerr_before", 32'(n_err - s_err), 0);
    tick();
    check("tmo_busy_after", 32'(bus.busy), 0);
    check("tmo_err_strobe", 32'(bus.command_error), 1);
    tick();
    check("tmo_nerr", 32'(n_err - s_err), 1);
    check("tmo_nwr", 32'(n_wr - s_wr), 0);
    check_fields("tmo");

    // reset in the middle of an ALU command
    s_err = n_err;
    send_byte(8'hCC, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    check("mid_opa_loaded", 32'(bus.operand_a), 32'h11);
    reset = 1'b1;
    #1;
    m_addr = '0; m_wdata = '0; m_a = '0; m_b = '0; m_func = '0;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check_fields("mid_rst");
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("mid_rst_noerr", 32'(n_err - s_err), 0);
    run_cmd("rd_after_rst", 1, 8'h01, 8'h00, 8'h00, 99, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      n = (kind == 0) ? 3 : (kind == 2) ? 4 : (kind == 4) ? 1 : 2;
      ca = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : 99;
      v = $urandom_range(0, 255);
      if (kind == 4) begin
        while (v == 8'hAA || v == 8'hBB || v == 8'hCC || v == 8'hDD) v = $urandom_range(0, 255);
      end
      run_cmd("rand", kind, 8'(v), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              ca, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0,
              1'($urandom_range(0, 1)));
    end

    check("one_strobe_per_cycle", 32'(n_multi), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
